// File: rtl/uart_rx_pkg.sv
// Shared types and widths for the UART receive front end.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;
  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = 3;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer; both stages reset high so an idle serial line reads as idle.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        meta_q[gi] <= 1'b1;
        sync_q[gi] <= 1'b1;
      end else begin
        meta_q[gi] <= d[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: mid-bit sampling of start/8 data/stop, LSB first,
// with a one-entry valid/ready holding register for the completed byte.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake; a good stop in the same cycle overrides below.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Holding off until the line returns high keeps a break from re-framing.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign bit_idx   = bit_idx_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit; timing is derived
// from the frame start cycle (start edge seen by the framer 3 edges after rx drops).
module tb_uart_rx_frame;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] bit_idx;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] stream_b [3] = '{8'h00, 8'hFF, 8'h55};

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at 1 time unit after edge number n.
  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of start/data/stop; an aborted frame leaves the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (nbits < 10) rx = 1'b1;
    $display("frame sent %02h stop=%0b bits=%0d", b, stop, nbits);
  endtask

  task automatic consume(input logic [7:0] exp);
    chk("cons_valid", rx_valid, 1);
    chk("cons_data", rx_data, exp);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    chk("cons_clear", rx_valid, 0);
    $display("byte consumed exp=%02h", exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, rx_data, 0);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_bit_idx"}, bit_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int c0, fe0, ov0, seen;

    #2 reset = 1'b1;
    #1 chk_reset("rst0");
    cycles(3);
    reset = 1'b0;
    cycles(5);

    // Single frame A5 with bit_idx stepping and latency check.
    fe0 = fe_cnt; ov0 = ov_cnt; c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 10);
      begin
        at_edge(c0 + 20);
        chk("a5_busy", busy, 1);
        chk("a5_idx0", bit_idx, 0);
        for (int i = 0; i < 7; i++) begin
          at_edge(c0 + 35 + 16 * i);
          chk("a5_idx_step", bit_idx, i + 1);
        end
        at_edge(c0 + 154);
        chk("a5_valid_early", rx_valid, 0);
        at_edge(c0 + 155);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_idle", busy, 0);
      end
    join
    chk("a5_ferr", fe_cnt - fe0, 0);
    chk("a5_ovr", ov_cnt - ov0, 0);
    $display("single frame A5 checked");

    // Reset mid-DATA while A5 is still held unconsumed.
    send_frame(8'hA5, 1'b1, 4);
    reset = 1'b1;
    #1 chk_reset("rst_mid");
    cycles(3);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      if (rx_valid) seen++;
    end
    chk("rst_no_valid", seen, 0);
    send_frame(8'hC3, 1'b1, 10);
    consume(8'hC3);

    // False start: 4-cycle glitch.
    fe0 = fe_cnt; c0 = cyc;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    at_edge(c0 + 5);
    chk("glitch_busy", busy, 1);
    at_edge(c0 + 12);
    chk("glitch_idle", busy, 0);
    cycles(32);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    $display("false start checked");

    // Framing error followed by break, then a good frame.
    fe0 = fe_cnt; c0 = cyc;
    fork
      send_frame(8'h3C, 1'b0, 10);
      begin
        at_edge(c0 + 155);
        chk("ferr_pulse", frame_err, 1);
        at_edge(c0 + 156);
        chk("ferr_pulse_end", frame_err, 0);
      end
    join
    cycles(48);
    chk("ferr_wait_busy", busy, 1);
    chk("ferr_valid", rx_valid, 0);
    chk("ferr_count", fe_cnt - fe0, 1);
    rx = 1'b1;
    cycles(8);
    chk("ferr_released", busy, 0);
    send_frame(8'h81, 1'b1, 10);
    consume(8'h81);

    // Overrun with consumer stalled.
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    chk("ovr_count", ov_cnt - ov0, 1);
    chk("ovr_data", rx_data, 8'h11);
    consume(8'h11);

    // Ready asserted exactly on the second good-stop cycle.
    ov0 = ov_cnt; c0 = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
      end
      begin
        at_edge(c0 + 314);
        chk("rdy_valid_pre", rx_valid, 1);
        chk("rdy_data_pre", rx_data, 8'h11);
        rx_ready = 1'b1;
        at_edge(c0 + 315);
        rx_ready = 1'b0;
        chk("rdy_valid_post", rx_valid, 1);
        chk("rdy_data_post", rx_data, 8'h22);
      end
    join
    chk("rdy_no_ovr", ov_cnt - ov0, 0);
    consume(8'h22);

    // Back-to-back stream consumed one cycle after each valid.
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      begin
        for (int k = 0; k < 3; k++) send_frame(stream_b[k], 1'b1, 10);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int t;
          t = 0;
          while (!rx_valid && t < 400) begin
            @(negedge clk);
            t++;
          end
          chk("stream_timeout", (t < 400), 1);
          chk("stream_data", rx_data, stream_b[k]);
          cycles(1);
          rx_ready = 1'b1;
          cycles(1);
          rx_ready = 1'b0;
          $display("stream byte %0d consumed exp=%02h", k, stream_b[k]);
        end
      end
    join
    cycles(4);
    chk("stream_ferr", fe_cnt - fe0, 0);
    chk("stream_ovr", ov_cnt - ov0, 0);
    chk("stream_valid_end", rx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
